mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Responder on the CPU data-memory port: a memory-mapped timer/compare peripheral that sits beside the data RAM.

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1FAF_0000, giving the 16-byte-aligned register window base.
REQ-002 SHALL have parameter RESET_PRESCALE, default 8'd0, giving the CTRL.PRESCALE reset value.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 dce  in  1  data access strobe from the CPU.
REQ-006 daddr  in  32  byte address; [3:2] selects the register.
REQ-007 we  in  4  byte-lane write enables; 4'b0000 with dce means read.
REQ-008 din  in  32  write data from the CPU.
REQ-009 dout  out  32  read data to the CPU.
REQ-010 irq  out  1  level interrupt request.

Function
REQ-011 Select SHALL be dce AND daddr[31:4]==BASE_ADDR[31:4]; unselected accesses SHALL change no state.
REQ-012 The register map by daddr[3:2] SHALL be: 0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS.
REQ-013 The CTRL fields SHALL be: [0] EN, [1] IE, [2] AUTO_RELOAD, [15:8] PRESCALE; all other bits SHALL read 0 and ignore writes.
REQ-014 STATUS[0] SHALL be MATCH, cleared by writing 1 (W1C) on lane 0; other STATUS bits SHALL read 0.
REQ-015 A write SHALL update only the byte lanes whose we bit is 1, taking effect at the end of the access cycle.
REQ-016 A read (select, we==0) SHALL drive dout with the register value sampled at that edge, valid from the next cycle (latency 1); otherwise dout SHALL hold its last value.
REQ-017 An 8-bit prescaler pre_cnt SHALL increment each cycle while EN=1; when pre_cnt==PRESCALE, the same cycle SHALL raise tick and reset pre_cnt to 0.
REQ-018 With PRESCALE=0, tick SHALL assert every cycle while EN=1; with PRESCALE=N, tick SHALL assert every N+1 cycles.
REQ-019 While EN=0, pre_cnt SHALL be held at 0 and COUNT SHALL hold.
REQ-020 On tick with COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTO_RELOAD=1, else COUNT<=COUNT+1.
REQ-021 On tick with COUNT!=COMPARE: COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF to 0 with no flag.
REQ-022 A CPU write to COUNT SHALL override a same-cycle tick increment; pre_cnt behaves per REQ-017 regardless.
REQ-023 A hardware MATCH set SHALL win over a same-cycle W1C.
REQ-024 Writing COMPARE SHALL not itself set MATCH; the comparison is only evaluated on tick.
REQ-025 irq SHALL equal MATCH AND IE, driven only from registers (no combinational path from inputs).

Reset
REQ-026 rst=1 SHALL asynchronously force: CTRL EN/IE/AUTO_RELOAD=0, PRESCALE=RESET_PRESCALE, COUNT=0, COMPARE=32'hFFFF_FFFF, MATCH=0, pre_cnt=0, dout=0, irq=0.
REQ-027 Reset asserted mid-access SHALL discard that access; the first access after rst deasserts SHALL behave normally.

Structure
REQ-028 Register offsets, CTRL bit positions and the window width SHALL live in the shared defines file alongside the existing bus-width macros.
REQ-029 The prescaler (pre_cnt, PRESCALE compare, tick output) SHALL be the one sub-module, mmio_timer_prescaler; all register, compare and bus logic SHALL stay in mmio_timer.

Verification
REQ-030 Reset then read offsets 0x0/0x4/0x8/0xC -> dout = 0x0000_0000 / 0 / 0xFFFF_FFFF / 0, each one cycle after its access.
REQ-031 Write CTRL=0x0000_0001 (PRESCALE=0, EN=1), COMPARE=5 -> COUNT increments every cycle; MATCH=1 on the tick where COUNT==5; COUNT continues to 6; irq stays 0 (IE=0).
REQ-032 Write CTRL=0x0000_0307 (PRESCALE=3, AUTO_RELOAD, IE, EN), COMPARE=2 -> tick every 4 cycles; COUNT sequence 0,1,2,0; irq rises with MATCH; W1C STATUS=1 drops irq the next cycle.
REQ-033 Write COUNT=0xFFFF_FFFF with we=4'b1111, EN=1, PRESCALE=0, COMPARE=0x10 -> next tick COUNT=0 and MATCH stays 0; then write COUNT with we=4'b0001, din=0xAB -> COUNT=0x0000_00AB.
REQ-034 Collisions: CPU writes COUNT=0x40 on a tick cycle -> COUNT=0x40, not incremented; W1C on the same cycle as a new match -> MATCH stays 1.
REQ-035 Access to BASE_ADDR+0x10 (outside the window) with we=4'b1111 -> no register changes and dout holds; rst pulsed mid-count -> all values of REQ-026 observed immediately.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL field
// positions, window width and the byte-lane merge helper.
package mmio_timer_pkg;

    localparam int unsigned BUS_W   = 32;
    localparam int unsigned WIN_LSB = 4;    // 16-byte register window

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_IE_BIT      = 1;
    localparam int unsigned CTRL_AR_BIT      = 2;
    localparam int unsigned CTRL_PS_LSB      = 8;
    localparam int unsigned STATUS_MATCH_BIT = 0;

    function automatic logic [BUS_W-1:0] merge_lanes(
        input logic [BUS_W-1:0] old_v,
        input logic [BUS_W-1:0] new_v,
        input logic [3:0]       be
    );
        logic [BUS_W-1:0] res;
        res = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler: counts enabled cycles and emits one tick every PRESCALE+1 cycles.
module mmio_timer_prescaler
    import mmio_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [7:0] i_prescale,
    output logic       o_tick
);

    logic [7:0] r_pre_cnt;

    assign o_tick = i_en && (r_pre_cnt == i_prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare peripheral on the CPU data port: CTRL, COUNT,
// COMPARE and W1C STATUS registers with a level interrupt.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h1FAF_0000,
    parameter logic [7:0]  RESET_PRESCALE = 8'd0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic        r_en;
    logic        r_ie;
    logic        r_ar;
    logic [7:0]  r_prescale;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_match;
    logic [31:0] r_dout;

    logic        w_sel;
    logic        w_wr;
    logic        w_rd;
    reg_sel_e    w_reg;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rdata;
    logic [31:0] w_count_nxt;
    logic        w_unused;

    assign w_sel    = dce && (daddr[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);
    assign w_wr     = w_sel && (we != 4'b0000);
    assign w_rd     = w_sel && (we == 4'b0000);
    assign w_reg    = reg_sel_e'(daddr[3:2]);
    assign w_hit    = (r_count == r_compare);
    assign w_unused = ^daddr[1:0];

    mmio_timer_prescaler u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_en),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            REG_CTRL: begin
                w_rdata[CTRL_EN_BIT]               = r_en;
                w_rdata[CTRL_IE_BIT]               = r_ie;
                w_rdata[CTRL_AR_BIT]               = r_ar;
                w_rdata[CTRL_PS_LSB +: 8]          = r_prescale;
            end
            REG_COUNT:   w_rdata = r_count;
            REG_COMPARE: w_rdata = r_compare;
            REG_STATUS:  w_rdata[STATUS_MATCH_BIT] = r_match;
            default:     w_rdata = '0;
        endcase
    end

    // CPU write to COUNT takes priority over a same-cycle tick.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && (w_reg == REG_COUNT)) begin
            w_count_nxt = merge_lanes(r_count, din, we);
        end else if (w_tick) begin
            w_count_nxt = (w_hit && r_ar) ? '0 : r_count + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_ar       <= 1'b0;
            r_prescale <= RESET_PRESCALE;
            r_count    <= '0;
            r_compare  <= '1;
            r_match    <= 1'b0;
            r_dout     <= '0;
        end else begin
            if (w_wr && (w_reg == REG_CTRL)) begin
                if (we[0]) begin
                    r_en <= din[CTRL_EN_BIT];
                    r_ie <= din[CTRL_IE_BIT];
                    r_ar <= din[CTRL_AR_BIT];
                end
                if (we[1]) r_prescale <= din[CTRL_PS_LSB +: 8];
            end
            r_count <= w_count_nxt;
            if (w_wr && (w_reg == REG_COMPARE)) begin
                r_compare <= merge_lanes(r_compare, din, we);
            end
            // A hardware match outranks a same-cycle clear.
            if (w_tick && w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr && (w_reg == REG_STATUS) && we[0] && din[STATUS_MATCH_BIT]) begin
                r_match <= 1'b0;
            end
            if (w_rd) r_dout <= w_rdata;
        end
    end

    assign dout = r_dout;
    assign irq  = r_match & r_ie;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer; all expectations hand-derived.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1FAF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_timer #(
        .BASE_ADDR      (BASE),
        .RESET_PRESCALE (8'd0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dce   (dce),
        .daddr (daddr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    // All tasks start and end on a falling edge; one access = one cycle.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        dce = 1'b1; daddr = addr; din = data; we = be;
        @(negedge clk);
        dce = 1'b0; we = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        dce = 1'b1; daddr = addr; we = 4'b0000;
        @(negedge clk);
        dce = 1'b0;
        data = dout;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h0000_0000; exp_v[1] = 32'h0000_0000;
        exp_v[2] = 32'hFFFF_FFFF; exp_v[3] = 32'h0000_0000;
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL reset_dout: got %h expected 00000000", dout); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4*i), v);
            n_cmp++; if (v !== exp_v[i]) begin n_err++; $display("FAIL reset_read[%0d]: got %h expected %h", i, v, exp_v[i]); end
        end
    endtask

    task automatic test_free_run;
        logic [31:0] v;
        do_reset();
        wr(BASE + 32'h8, 32'd5, 4'b1111);
        wr(BASE + 32'h0, 32'h0000_0001, 4'b1111);
        for (int j = 1; j <= 7; j++) begin
            rd(BASE + 32'h4, v);
            n_cmp++; if (v !== 32'(j - 1)) begin n_err++; $display("FAIL free_count[%0d]: got %h expected %h", j, v, 32'(j - 1)); end
            n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL free_irq[%0d]: got %b expected 0", j, irq); end
        end
        rd(BASE + 32'hC, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL free_match: got %h expected 00000001", v); end
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        logic [31:0] e;
        do_reset();
        wr(BASE + 32'h8, 32'd2, 4'b1111);
        wr(BASE + 32'h0, 32'h0000_0307, 4'b1111);
        for (int j = 1; j <= 14; j++) begin
            n_cmp++; if (irq !== (j >= 13)) begin n_err++; $display("FAIL ar_irq[%0d]: got %b expected %b", j, irq, (j >= 13)); end
            rd(BASE + 32'h4, v);
            e = (j < 5) ? 32'd0 : (j < 9) ? 32'd1 : (j < 13) ? 32'd2 : 32'd0;
            n_cmp++; if (v !== e) begin n_err++; $display("FAIL ar_count[%0d]: got %h expected %h", j, v, e); end
        end
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL ar_irq_before_w1c: got %b expected 1", irq); end
        wr(BASE + 32'hC, 32'h1, 4'b0001);
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq_after_w1c: got %b expected 0", irq); end
        rd(BASE + 32'hC, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL ar_status_after_w1c: got %h expected 00000000", v); end
    endtask

    task automatic test_wrap;
        logic [31:0] v;
        do_reset();
        wr(BASE + 32'h8, 32'h10, 4'b1111);
        wr(BASE + 32'h0, 32'h0000_0001, 4'b1111);
        wr(BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111);
        rd(BASE + 32'h4, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_written: got %h expected ffffffff", v); end
        rd(BASE + 32'h4, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL wrap_zero: got %h expected 00000000", v); end
        rd(BASE + 32'hC, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL wrap_no_match: got %h expected 00000000", v); end
        wr(BASE + 32'h4, 32'h0000_00AB, 4'b0001);
        rd(BASE + 32'h4, v);
        n_cmp++; if (v !== 32'h0000_00AB) begin n_err++; $display("FAIL wrap_lane0: got %h expected 000000ab", v); end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        do_reset();
        wr(BASE + 32'h8, 32'd3, 4'b1111);
        wr(BASE + 32'h0, 32'h0000_0001, 4'b1111);
        repeat (3) @(negedge clk);
        wr(BASE + 32'hC, 32'h1, 4'b0001);
        rd(BASE + 32'hC, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL coll_match_wins: got %h expected 00000001", v); end
        wr(BASE + 32'h4, 32'h40, 4'b1111);
        rd(BASE + 32'h4, v);
        n_cmp++; if (v !== 32'h40) begin n_err++; $display("FAIL coll_count_write: got %h expected 00000040", v); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL coll_irq: got %b expected 0", irq); end
    endtask

    task automatic test_outside;
        logic [31:0] v;
        do_reset();
        rd(BASE + 32'h8, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL out_prime: got %h expected ffffffff", v); end
        wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'b1111);
        n_cmp++; if (dout !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL out_hold_wr: got %h expected ffffffff", dout); end
        rd(BASE + 32'h18, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL out_hold_rd: got %h expected ffffffff", v); end
        dce = 1'b0; daddr = BASE + 32'h4; din = 32'h1234; we = 4'b1111;
        @(negedge clk);
        we = 4'b0000;
        rd(BASE + 32'h0, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL out_ctrl: got %h expected 00000000", v); end
        rd(BASE + 32'h4, v);
        n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL out_count: got %h expected 00000000", v); end
        rd(BASE + 32'h8, v);
        n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL out_compare: got %h expected ffffffff", v); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h0; exp_v[1] = 32'h0; exp_v[2] = 32'hFFFF_FFFF; exp_v[3] = 32'h0;
        do_reset();
        wr(BASE + 32'h8, 32'd1, 4'b1111);
        wr(BASE + 32'h0, 32'h0000_0307, 4'b1111);
        rd(BASE + 32'h8, v);
        n_cmp++; if (v !== 32'h1) begin n_err++; $display("FAIL mid_compare: got %h expected 00000001", v); end
        repeat (8) @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL mid_irq_pre: got %b expected 1", irq); end
        rst = 1'b1; dce = 1'b1; daddr = BASE + 32'h8; din = 32'h55; we = 4'b1111;
        #1;
        n_cmp++; if (dout !== 32'h0) begin n_err++; $display("FAIL mid_dout_async: got %h expected 00000000", dout); end
        n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mid_irq_async: got %b expected 0", irq); end
        @(negedge clk);
        rst = 1'b0; dce = 1'b0; we = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            rd(BASE + 32'(4*i), v);
            n_cmp++; if (v !== exp_v[i]) begin n_err++; $display("FAIL mid_read[%0d]: got %h expected %h", i, v, exp_v[i]); end
        end
        wr(BASE + 32'h8, 32'h55, 4'b1111);
        rd(BASE + 32'h8, v);
        n_cmp++; if (v !== 32'h55) begin n_err++; $display("FAIL mid_first_access: got %h expected 00000055", v); end
    endtask

    initial begin
        rst = 1'b1; dce = 1'b0; daddr = '0; din = '0; we = 4'b0000;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_autoreload();
        test_wrap();
        test_collision();
        test_outside();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
